// File: rtl/push_debouncer_pkg.sv
// Shared types and default 50 MHz timing constants for the push-button debouncer.
package push_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } deb_state_t;

   localparam int DEB_CYC_50MHZ_20MS  = 1_000_000;
   localparam int REP_DLY_50MHZ_500MS = 25_000_000;
   localparam int REP_PER_50MHZ_100MS = 5_000_000;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/push_debounce_ch.sv
// Single-button channel: 2-flop synchroniser, debounce FSM and stability counter.
// Optional hold-to-repeat press strobes when PUSH_DEBOUNCER_REPEAT_EN is defined.
module push_debounce_ch
   import push_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = DEB_CYC_50MHZ_20MS,
   parameter int REPEAT_DLY_CYC = REP_DLY_50MHZ_500MS,
   parameter int REPEAT_PER_CYC = REP_PER_50MHZ_100MS
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pushRaw_i,
   output logic push_o,
   output logic press_o,
   output logic release_o
);

   localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic syncA_q, syncB_q;
   deb_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic push_q, push_d;
   logic press_q, press_d;
   logic release_q, release_d;
   logic repFire;

   // Synchroniser idles at 1 so reset looks like a released button.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         syncA_q <= 1'b1;
         syncB_q <= 1'b1;
      end else begin
         syncA_q <= pushRaw_i;
         syncB_q <= syncA_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         push_q    <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         push_q    <= push_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Any disagreement with the candidate level drops back and restarts the check.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RELEASED: begin
            if (!syncB_q) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (syncB_q) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (syncB_q) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end
         end
         RELEASE_CHK: begin
            if (!syncB_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

   always_comb begin
      push_d    = push_q;
      press_d   = repFire;
      release_d = 1'b0;
      unique case (state_q)
         PRESS_CHK: begin
            if (!syncB_q && cnt_q == CNT_LAST) begin
               push_d  = 1'b0;
               press_d = 1'b1;
            end
         end
         RELEASE_CHK: begin
            if (syncB_q && cnt_q == CNT_LAST) begin
               push_d    = 1'b1;
               release_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef PUSH_DEBOUNCER_REPEAT_EN
   localparam int RW = $clog2(maxInt(REPEAT_DLY_CYC, REPEAT_PER_CYC));
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY_CYC - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER_CYC - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic repPeriodic_q, repPeriodic_d;

   // Hold timer counts only in PRESSED, freezes in RELEASE_CHK, clears in RELEASED.
   always_comb begin
      rep_d         = rep_q;
      repPeriodic_d = repPeriodic_q;
      repFire       = 1'b0;
      if (state_q == RELEASED) begin
         rep_d         = '0;
         repPeriodic_d = 1'b0;
      end else if (state_q == PRESSED) begin
         if (rep_q == (repPeriodic_q ? PER_LAST : DLY_LAST)) begin
            repFire       = 1'b1;
            rep_d         = '0;
            repPeriodic_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rep_q         <= '0;
         repPeriodic_q <= 1'b0;
      end else begin
         rep_q         <= rep_d;
         repPeriodic_q <= repPeriodic_d;
      end
   end
`else
   assign repFire = 1'b0;
`endif

   assign push_o    = push_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/push_debouncer.sv
// Multi-button debouncer: one independent push_debounce_ch per button bit.
// Define PUSH_DEBOUNCER_REPEAT_EN to enable hold-to-repeat press strobes.
module push_debouncer
   import push_debouncer_pkg::*;
#(
   parameter int NUM_BTN        = 2,
   parameter int DEBOUNCE_CYC   = DEB_CYC_50MHZ_20MS,
   parameter int REPEAT_DLY_CYC = REP_DLY_50MHZ_500MS,
   parameter int REPEAT_PER_CYC = REP_PER_50MHZ_100MS
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [NUM_BTN-1:0] i_Push,
   output logic [NUM_BTN-1:0] o_Push,
   output logic [NUM_BTN-1:0] o_Press,
   output logic [NUM_BTN-1:0] o_Release
);

   for (genvar b = 0; b < NUM_BTN; b++) begin : gChannel
      push_debounce_ch #(
         .DEBOUNCE_CYC   (DEBOUNCE_CYC),
         .REPEAT_DLY_CYC (REPEAT_DLY_CYC),
         .REPEAT_PER_CYC (REPEAT_PER_CYC)
      ) uChannel (
         .clk_i     (i_Clk),
         .rst_i     (i_Rst),
         .pushRaw_i (i_Push[b]),
         .push_o    (o_Push[b]),
         .press_o   (o_Press[b]),
         .release_o (o_Release[b])
      );
   end

endmodule

// File: tb/tb_push_debouncer.sv
// Directed scoreboard bench for push_debouncer (DEBOUNCE_CYC=4, repeat 20/8).
module tb_push_debouncer;

   localparam int DEB  = 4;
   localparam int RDLY = 20;
   localparam int RPER = 8;
   localparam int LAT  = DEB + 3;

   typedef struct {
      int         cyc;
      logic [1:0] press;
      logic [1:0] rel;
   } exp_t;

   logic       i_Clk = 1'b0;
   logic       i_Rst;
   logic [1:0] i_Push;
   logic [1:0] o_Push, o_Press, o_Release;

   exp_t       expQ[$];
   int         edgeCnt = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [1:0] expPush;

   always #5 i_Clk = ~i_Clk;

   push_debouncer #(
      .NUM_BTN        (2),
      .DEBOUNCE_CYC   (DEB),
      .REPEAT_DLY_CYC (RDLY),
      .REPEAT_PER_CYC (RPER)
   ) dut (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Push    (i_Push),
      .o_Push    (o_Push),
      .o_Press   (o_Press),
      .o_Release (o_Release)
   );

   task automatic expectEvent(input int cyc, input logic [1:0] p, input logic [1:0] r);
      exp_t e;
      e.cyc   = cyc;
      e.press = p;
      e.rel   = r;
      expQ.push_back(e);
   endtask

   // Pops every event due on this edge; anything not scheduled must be quiet.
   task automatic checkOutput();
      exp_t e;
      logic [1:0] ep = 2'b00;
      logic [1:0] er = 2'b00;
      while (expQ.size() > 0 && expQ[0].cyc == edgeCnt) begin
         e  = expQ.pop_front();
         ep = ep | e.press;
         er = er | e.rel;
      end
      expPush = (expPush & ~ep) | er;
      vectors++;
      assert (o_Press === ep) else begin
         miscompares++;
         $error("[TB] FAIL press edge=%0d got=%b want=%b", edgeCnt, o_Press, ep);
      end
      vectors++;
      assert (o_Release === er) else begin
         miscompares++;
         $error("[TB] FAIL release edge=%0d got=%b want=%b", edgeCnt, o_Release, er);
      end
      vectors++;
      assert (o_Push === expPush) else begin
         miscompares++;
         $error("[TB] FAIL push edge=%0d got=%b want=%b", edgeCnt, o_Push, expPush);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         edgeCnt++;
         #1;
         checkOutput();
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v);
      i_Push = v;
   endtask

   initial begin
      int acc;
      i_Rst   = 1'b1;
      i_Push  = 2'b00;
      expPush = 2'b11;

      $display("[TB] reset with both buttons held");
      step(3);
      i_Rst = 1'b0;
      expectEvent(edgeCnt + LAT, 2'b11, 2'b00);
      step(10);
      applyStimulus(2'b11);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b11);
      step(12);

      $display("[TB] clean press and release of bit 0");
      applyStimulus(2'b10);
      expectEvent(edgeCnt + LAT, 2'b01, 2'b00);
      step(10);
      applyStimulus(2'b11);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b01);
      step(12);

      $display("[TB] bouncing press of bit 1");
      repeat (3) begin
         applyStimulus(2'b01);
         step(3);
         applyStimulus(2'b11);
         step(1);
      end
      applyStimulus(2'b01);
      expectEvent(edgeCnt + LAT, 2'b10, 2'b00);
      step(10);
      applyStimulus(2'b11);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b10);
      step(12);

      $display("[TB] short glitch on bit 0");
      applyStimulus(2'b10);
      step(3);
      applyStimulus(2'b11);
      step(12);

      $display("[TB] simultaneous press, staggered release");
      applyStimulus(2'b00);
      expectEvent(edgeCnt + LAT, 2'b11, 2'b00);
      step(10);
      applyStimulus(2'b01);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b01);
      step(2);
      applyStimulus(2'b11);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b10);
      step(12);

      $display("[TB] long hold on bit 0");
      applyStimulus(2'b10);
      acc = edgeCnt + LAT;
      expectEvent(acc, 2'b01, 2'b00);
`ifdef PUSH_DEBOUNCER_REPEAT_EN
      for (int k = 0; k < 4; k++) begin
         expectEvent(acc + RDLY + k * RPER, 2'b01, 2'b00);
      end
`endif
      step(LAT + 46);
      applyStimulus(2'b11);
      expectEvent(edgeCnt + LAT, 2'b00, 2'b01);
      step(12);

      vectors++;
      assert (expQ.size() == 0) else begin
         miscompares++;
         $error("[TB] FAIL pending_events got=%0d want=0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/push_debouncer.md
# push_debouncer

Push-button conditioning stage feeding the up/down counter's `i_Push` input. It synchronises raw, bouncing, active-low button levels into `i_Clk` and filters each button with a stable-time counter. It outputs clean active-low levels as a drop-in for the counter's `i_Push`, plus single-cycle press and release strobes for downstream logic. It can optionally generate hold-to-repeat press strobes.

## Interface
- `NUM_BTN`, 2: number of buttons; one independent channel per bit.
- `DEBOUNCE_CYC`, 1_000_000: required stable cycles (20 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_DLY_CYC`, 25_000_000: hold time before the first repeat strobe (500 ms); used only with repeat.
- `REPEAT_PER_CYC`, 5_000_000: repeat strobe period (100 ms); used only with repeat; ≥ 2.
- `i_Clk`  in  1  system clock, 50 MHz.
- `i_Rst`  in  1  reset, asynchronous, active-high.
- `i_Push`  in  NUM_BTN  raw button levels, active-low (0 = pressed), asynchronous to `i_Clk`.
- `o_Push`  out  NUM_BTN  debounced level, active-low, registered.
- `o_Press`  out  NUM_BTN  one-cycle strobe per accepted press (and per repeat).
- `o_Release`  out  NUM_BTN  one-cycle strobe per accepted release.

## Operation
- Two-flop synchroniser per bit. Both flops reset to 1 (released). The synchronised bit is `s`.
- Per-channel FSM with four states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. It has a stability counter of width `$clog2(DEBOUNCE_CYC)`.
- RELEASED: when `s`=0, go to PRESS_CHK and set cnt=0.
- PRESS_CHK:
  - If `s`=1, return to RELEASED. This is a glitch: no strobe, and `o_Push` is unchanged.
  - Otherwise, if cnt = DEBOUNCE_CYC-1, go to PRESSED, drive the `o_Push` bit to 0, and pulse `o_Press`.
  - Otherwise, increment cnt.
- PRESSED: when `s`=1, go to RELEASE_CHK and set cnt=0.
- RELEASE_CHK:
  - If `s`=0, return to PRESSED with no strobe.
  - If cnt = DEBOUNCE_CYC-1, go to RELEASED, drive the `o_Push` bit to 1, and pulse `o_Release`.
  - Otherwise, increment cnt.
- Any bounce restarts the check from zero. The counter never wraps, because it is cleared on every state entry.
- Channels are fully independent. Simultaneous events on several buttons produce strobes in the same cycle.
- Reset values: `o_Push` = all 1s, `o_Press` = 0, `o_Release` = 0, every FSM in RELEASED, all counters 0.
- Reset mid-check or mid-hold: no strobe is emitted. After reset deassertion, a button held low re-qualifies through PRESS_CHK and then emits `o_Press`.

## Timing
- If the raw edge is stable from before clock edge 1, `o_Push` changes and the strobe asserts at edge DEBOUNCE_CYC+3.
  - 2 cycles are for synchronisation and 1 for state entry.
  - The same latency applies to presses and releases.
- Strobes are high for exactly one cycle and coincide with the `o_Push` transition.
- A minimum of DEBOUNCE_CYC+1 cycles separates a press strobe from the following release strobe.
- Pulses shorter than DEBOUNCE_CYC synchronised cycles are fully rejected.

## Configuration
- Macro: `PUSH_DEBOUNCER_REPEAT_EN`.
- Defined: each channel has a repeat counter that runs only in PRESSED.
  - An extra `o_Press` fires REPEAT_DLY_CYC cycles after entering PRESSED, then every REPEAT_PER_CYC cycles.
  - The counter freezes during RELEASE_CHK. It resumes if the channel returns to PRESSED and clears on entering RELEASED.
  - `o_Push` is unaffected by repeat.
- Undefined: no repeat counter is synthesised, and exactly one `o_Press` occurs per accepted press.

## Structure
- Package `push_debouncer_pkg`:
  - state enum typedef `deb_state_t` (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK);
  - default timing constants (`DEB_CYC_50MHZ_20MS`, `REP_DLY_50MHZ_500MS`, `REP_PER_50MHZ_100MS`).
- Sub-module `push_debounce_ch`: one synchroniser, FSM and counter(s) for a single button. The top instantiates it NUM_BTN times in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, REPEAT_DLY_CYC=20, REPEAT_PER_CYC=8.

1. Reset: assert `i_Rst` with `i_Push`=2'b00 -> `o_Push`=2'b11 and strobes 0 during reset. After release, `o_Push`=2'b00 at edge 7 and `o_Press`=2'b11 for one cycle.
2. Clean press of bit 0 (2'b10 from edge 1) -> `o_Push`=2'b10 and `o_Press`=2'b01 at edge 7 only. Releasing the button later -> `o_Release`=2'b01 exactly 7 cycles after the raw edge.
3. Bounce: raw bit 1 toggling low 3 cycles / high 1 cycle, then stable low -> no strobe during bouncing; `o_Press`=2'b10 exactly 7 cycles after the final stable edge.
4. Glitch: a 3-cycle low pulse on bit 0 -> `o_Push` stays 2'b11 with no strobes.
5. Simultaneous press of both bits -> `o_Press`=2'b11 in one cycle. Staggered release by 2 cycles -> two `o_Release` strobes 2 cycles apart.
6. With `PUSH_DEBOUNCER_REPEAT_EN`, hold bit 0 for 50 cycles after acceptance -> `o_Press` at +0, +20, +28, +36, +44. Without the macro -> only the +0 strobe.
